// File: rtl/alu_tx_sequencer.sv
// Sequences the four-bit ALU through operand load and execute, then ships the result over the UART.
// Define SEQ_ASCII_EN to send the result as two uppercase ASCII hex digits plus CR instead of one raw byte.
module alu_tx_sequencer #(
    parameter int unsigned SETTLE_CYCLES = 2,
    parameter int unsigned BUSY_TIMEOUT  = 255
) (
    input  logic       clk,
    input  logic       reset_n,
    input  logic       start,
    input  logic [3:0] op_a,
    input  logic [3:0] op_b,
    input  logic [3:0] op_sel,
    input  logic [7:0] alu_result,
    input  logic       uart_busy,
    output logic [3:0] data_input,
    output logic       save_a_n,
    output logic       save_b_n,
    output logic [3:0] alu_ena,
    output logic       uart_tx_en,
    output logic [7:0] uart_data,
    output logic       seq_busy,
    output logic       done,
    output logic       error
);

    typedef enum logic [2:0] {
        S_IDLE,
        S_LOAD_A,
        S_LOAD_B,
        S_EXEC,
        S_SEND,
        S_WAIT_ACK,
        S_WAIT_IDLE,
        S_DONE
    } state_t;

    localparam logic [3:0] SETTLE_LOAD = 4'(SETTLE_CYCLES - 1);
    localparam logic [7:0] TMO_LOAD    = 8'(BUSY_TIMEOUT - 1);

`ifdef SEQ_ASCII_EN
    localparam logic [1:0] LAST_IDX = 2'd2;

    function automatic logic [7:0] hex_char(input logic [3:0] n);
        return (n < 4'd10) ? (8'h30 + {4'h0, n}) : (8'h37 + {4'h0, n});
    endfunction

    function automatic logic [7:0] tx_byte(input logic [7:0] r, input logic [1:0] idx);
        case (idx)
            2'd0:    return hex_char(r[7:4]);
            2'd1:    return hex_char(r[3:0]);
            default: return 8'h0D;
        endcase
    endfunction
`else
    localparam logic [1:0] LAST_IDX = 2'd0;

    function automatic logic [7:0] tx_byte(input logic [7:0] r, input logic [1:0] idx);
        return (idx == 2'd0) ? r : 8'h00;
    endfunction
`endif

    state_t     state, state_next;
    logic [3:0] a_q, b_q, op_q;
    logic [3:0] settle_cnt;
    logic [7:0] tmo_cnt;
    logic [7:0] result_q;
    logic [1:0] byte_idx;
    logic       tmo_expired;
    logic       last_byte;

    // The strobe cycle counts as the first elapsed timeout cycle.
    assign tmo_expired = (tmo_cnt <= 8'd1);
    assign last_byte   = (byte_idx == LAST_IDX);

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state <= S_IDLE;
        end else begin
            state <= state_next;
        end
    end

    always_comb begin
        state_next = state;
        data_input = '0;
        save_a_n   = 1'b1;
        save_b_n   = 1'b1;
        alu_ena    = '0;
        uart_tx_en = 1'b0;
        seq_busy   = 1'b1;
        done       = 1'b0;
        case (state)
            S_IDLE: begin
                seq_busy = 1'b0;
                if (start) state_next = S_LOAD_A;
            end
            S_LOAD_A: begin
                data_input = a_q;
                save_a_n   = 1'b0;
                state_next = S_LOAD_B;
            end
            S_LOAD_B: begin
                data_input = b_q;
                save_b_n   = 1'b0;
                state_next = S_EXEC;
            end
            S_EXEC: begin
                alu_ena = op_q;
                if (settle_cnt == '0) state_next = S_SEND;
            end
            S_SEND: begin
                alu_ena = op_q;
                if (!uart_busy) begin
                    uart_tx_en = 1'b1;
                    state_next = S_WAIT_ACK;
                end
            end
            S_WAIT_ACK: begin
                alu_ena = op_q;
                // A busy rise in the expiry cycle still counts as an acknowledge.
                if (uart_busy)        state_next = S_WAIT_IDLE;
                else if (tmo_expired) state_next = S_DONE;
            end
            S_WAIT_IDLE: begin
                alu_ena = op_q;
                if (!uart_busy) state_next = last_byte ? S_DONE : S_SEND;
            end
            S_DONE: begin
                alu_ena    = op_q;
                done       = 1'b1;
                state_next = S_IDLE;
            end
            default: state_next = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            a_q        <= '0;
            b_q        <= '0;
            op_q       <= '0;
            settle_cnt <= '0;
            tmo_cnt    <= '0;
            result_q   <= '0;
            byte_idx   <= '0;
            uart_data  <= '0;
            error      <= 1'b0;
        end else begin
            case (state)
                S_IDLE: begin
                    if (start) begin
                        a_q   <= op_a;
                        b_q   <= op_b;
                        op_q  <= op_sel;
                        error <= 1'b0;
                    end
                end
                S_LOAD_B: settle_cnt <= SETTLE_LOAD;
                S_EXEC: begin
                    if (settle_cnt == '0) begin
                        result_q  <= alu_result;
                        uart_data <= tx_byte(alu_result, 2'd0);
                        byte_idx  <= '0;
                    end else begin
                        settle_cnt <= settle_cnt - 4'd1;
                    end
                end
                S_SEND: begin
                    if (!uart_busy) tmo_cnt <= TMO_LOAD;
                end
                S_WAIT_ACK: begin
                    if (!uart_busy) begin
                        if (tmo_expired) error <= 1'b1;
                        else             tmo_cnt <= tmo_cnt - 8'd1;
                    end
                end
                S_WAIT_IDLE: begin
                    if (!uart_busy && !last_byte) begin
                        byte_idx  <= byte_idx + 2'd1;
                        uart_data <= tx_byte(result_q, byte_idx + 2'd1);
                    end
                end
                default: ;
            endcase
        end
    end

endmodule

// File: doc/alu_tx_sequencer.md
# alu_tx_sequencer

Control sequencer that drives the four-bit ALU through one complete operation and ships the result out through the UART transmitter. On a `start` pulse it latches operands and opcode, strobes them into the ALU's A/B registers, and waits a programmable settle time. It then captures the ALU result and hands it to the UART byte by byte using the tx_en/busy handshake. It sits between the top-level pin wrapper and the `four_bit_alu`/UART pair, replacing manual save/enable pin toggling.

## Interface
Parameters:
- `SETTLE_CYCLES`, default 2: cycles spent in EXEC with the opcode applied before the result is captured; legal range 1-15.
- `BUSY_TIMEOUT`, default 255: maximum cycles to wait for `uart_busy` to rise after a tx_en strobe; legal range 1-255.

Ports:
- `clk` in 1: single clock; all state is on the rising edge.
- `reset_n` in 1: asynchronous, active-low reset.
- `start` in 1: level-sampled request; it is accepted only in IDLE.
- `op_a` in 4: operand A, latched on accept.
- `op_b` in 4: operand B, latched on accept.
- `op_sel` in 4: ALU opcode/enable pattern, latched on accept.
- `alu_result` in 8: ALU result bus.
- `uart_busy` in 1: UART transmitter busy.
- `data_input` out 4: ALU operand bus.
- `save_a_n` out 1: active-low A-register strobe.
- `save_b_n` out 1: active-low B-register strobe.
- `alu_ena` out 4: opcode to the ALU.
- `uart_tx_en` out 1: one-cycle transmit strobe.
- `uart_data` out 8: byte to transmit, stable from the strobe until busy falls.
- `seq_busy` out 1: high in every state except IDLE.
- `done` out 1: one-cycle completion pulse.
- `error` out 1: sticky UART timeout flag.

## Operation
State machine: IDLE → LOAD_A → LOAD_B → EXEC → SEND → WAIT_ACK → WAIT_IDLE → (SEND | DONE) → IDLE.
- **IDLE:** when `start`=1, latch `op_a`, `op_b` and `op_sel`; clear `error`; go to LOAD_A.
- **LOAD_A:** `data_input`=A, `save_a_n`=0 for exactly one cycle.
- **LOAD_B:** `data_input`=B, `save_b_n`=0 for exactly one cycle.
- **EXEC:** `alu_ena`=opcode.
  - After `SETTLE_CYCLES` cycles, capture `alu_result` into the tx register and go to SEND.
  - `alu_ena` holds the opcode from EXEC through DONE and is 0 in IDLE.
- **SEND:** wait while `uart_busy`=1. When `uart_busy`=0, drive `uart_tx_en`=1 for one cycle with the current byte on `uart_data`, then go to WAIT_ACK.
- **WAIT_ACK:** wait for `uart_busy`=1, then go to WAIT_IDLE.
  - If `uart_busy` has not risen after `BUSY_TIMEOUT` cycles, set `error` and go to DONE, abandoning any remaining bytes.
- **WAIT_IDLE:** wait for `uart_busy`=0. If bytes remain, go to SEND; otherwise go to DONE.
- **DONE:** `done`=1 for one cycle, then IDLE. `done` also pulses on the error path.
- **Outside load states:** `data_input`=0; both save strobes are 1.
- **Start handling:** `start` outside IDLE is ignored and not queued. A `start` held high re-triggers on the cycle after DONE.

## Timing
- **Reset values:** `data_input`=0, `save_a_n`=1, `save_b_n`=1, `alu_ena`=0, `uart_tx_en`=0, `uart_data`=0, `seq_busy`=0, `done`=0, `error`=0, state=IDLE.
- **Reset mid-operation:** all outputs return to their reset values asynchronously, including `uart_tx_en` in the middle of a strobe. The remaining tx bytes are discarded.
- **Latency:** call the start-accept edge cycle 0.
  - LOAD_A is cycle 1 and LOAD_B is cycle 2.
  - EXEC covers cycles 3 to 2+`SETTLE_CYCLES`.
  - The first `uart_tx_en` falls in cycle 3+`SETTLE_CYCLES` if `uart_busy`=0, which is cycle 5 at the default.
- **Result capture:** the result is sampled on the last EXEC cycle; `alu_result` changes after that are ignored.
- **Settle counter:** 4 bits, reloaded on entry to EXEC.
- **Timeout counter:** 8 bits, reloaded on each strobe.
- **Simultaneous events:** if `uart_busy` rises in the same cycle the timeout expires, busy wins (no error).

## Configuration
- **Macro `SEQ_ASCII_EN` defined:** the result is sent as three bytes.
  - Byte 1: ASCII uppercase hex of the high nibble.
  - Byte 2: ASCII uppercase hex of the low nibble.
  - Byte 3: 0x0D.
  - Nibble mapping: 0-9 → 0x30-0x39, A-F → 0x41-0x46.
- **Macro `SEQ_ASCII_EN` not defined:** a single raw byte equal to the captured result is sent.

## Test plan
- **Basic pulse timing:** reset, A=3, B=5, op=0001, start one cycle, UART model raises busy 1 cycle after the strobe for 10 cycles → `save_a_n` low in cycle 1 with `data_input`=3, `save_b_n` low in cycle 2 with `data_input`=5, `alu_ena`=0001 from cycle 3, first `uart_tx_en` in cycle 5.
- **Payload:** `alu_result`=0x3C → with `SEQ_ASCII_EN`, bytes 0x33, 0x43, 0x0D in order with one `done` pulse; without it, one byte 0x3C then `done`.
- **Back-pressure:** hold `uart_busy`=1 for 20 cycles on SEND entry → no strobe until busy falls, then the strobe on the first cycle busy is low.
- **Timeout:** `uart_busy` never rises → `error`=1 and `done` pulse exactly 255 cycles after the strobe; the next accepted start clears `error`.
- **Start while busy:** pulse `start` during EXEC with different operands → ignored, and the original operands' result is transmitted.
- **Reset mid-transmit:** assert `reset_n`=0 in WAIT_IDLE → all outputs immediately at reset values; after release, a new start runs a full clean sequence.
